imem_fetch_port: RTL and testbench
==================================

IMEM_FETCH_PORT -- requirements
Module: imem_fetch_port

Interface
REQ-001 DEPTH, 16, number of XLEN-bit instruction words; power of two, >=4.
REQ-002 XLEN, 32, instruction and byte-address width.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_addr  input  XLEN  fetch byte address.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready at clk edge.
REQ-008 rsp_valid  output  1  response present.
REQ-009 rsp_instr  output  XLEN  fetched instruction word.
REQ-010 rsp_addr  output  XLEN  byte address of the request that produced this response.
REQ-011 rsp_fault  output  1  response is faulted (see Configuration).
REQ-012 rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready.
REQ-013 flush  input  1  discard all in-flight and buffered responses (redirect).
REQ-014 wr_en, wr_addr (XLEN), wr_data (XLEN)  input  program-load word-write port.

Function
REQ-015 Word index SHALL be req_addr[$clog2(DEPTH)+1:2]; memory read synchronous.
REQ-016 Latency SHALL be 1: accept at edge N, rsp_valid at edge N+1 when output buffer empty.
REQ-017 Responses SHALL pass through a 2-entry in-order FIFO; sustained throughput 1 response/cycle with rsp_ready held 1.
REQ-018 req_ready SHALL be 1 iff reset deasserted, wr_en=0 and (FIFO occupancy + in-flight) < 2 — registered state only; no combinational path from rsp_ready.
REQ-019 While rsp_valid && !rsp_ready, rsp_instr/rsp_addr/rsp_fault SHALL hold stable.
REQ-020 FIFO full: no acceptance, no overwrite, no dropped response.
REQ-021 flush=1 SHALL discard in-flight and buffered entries; rsp_valid=0 on the next cycle; a request accepted in the flush cycle SHALL survive and appear one cycle later.
REQ-022 wr_en=1 SHALL write wr_data to word wr_addr at the edge; a read of that word accepted the next cycle SHALL return the new data.
REQ-023 Memory array SHALL initialise to all-zero at time 0; reset SHALL NOT clear it.

Reset
REQ-024 While reset=0: req_ready=0, rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_fault=0; FIFO pointers and in-flight flag cleared.
REQ-025 Reset mid-operation SHALL drop all pending responses; first acceptance possible on the cycle after reset=1 is sampled.

Configuration
REQ-026 IMEM_FAULT_CHECK_EN defined: rsp_fault=1 if req_addr[1:0]!=0 or req_addr >= DEPTH*4; faulted response has rsp_instr=0, still occupies a FIFO slot, order preserved.
REQ-027 IMEM_FAULT_CHECK_EN undefined: rsp_fault tied 0, req_addr[1:0] ignored, out-of-range addresses alias modulo DEPTH.

Structure
REQ-028 Package imem_pkg SHALL hold the response struct (instr, addr, fault) and constant IMEM_FIFO_DEPTH=2.
REQ-029 Response buffer SHALL be sub-module imem_rsp_fifo (parametrised on the pkg struct).

Verification
REQ-030 Preload words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 via wr port; stream req 0x0,0x4,0x8,0xC, rsp_ready=1 -> four back-to-back responses, first 1 cycle after accept, rsp_addr matches.
REQ-031 req_valid=1, rsp_ready=0 for 5 cycles -> exactly 2 accepts, req_ready=0, outputs stable; rsp_ready=1 -> drain in order.
REQ-032 flush with 2 buffered entries and simultaneous req 0x20 -> old entries dropped, next response rsp_addr=0x20, word 8.
REQ-033 DEPTH=16: req 0x6 and 0x40 -> rsp_fault=1 with macro; without macro 0x40 returns word 0, rsp_fault=0.
REQ-034 Assert reset with 2 pending -> next cycle rsp_valid=0, req_ready=0; after release re-fetch 0x4 returns 0x00A00113.
REQ-035 wr_en to word 5 with 0xDEADBEEF, read 0x14 next cycle -> rsp_instr=0xDEADBEEF; req_ready=0 during write cycle.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

  localparam int IMEM_XLEN       = 32;
  localparam int IMEM_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [IMEM_XLEN-1:0] instr;
    logic [IMEM_XLEN-1:0] addr;
    logic                 fault;
  } rsp_t;

  // A faulted response never leaks memory contents.
  function automatic rsp_t make_rsp(input logic [IMEM_XLEN-1:0] word,
                                    input logic [IMEM_XLEN-1:0] addr,
                                    input logic                 fault);
    rsp_t r;
    r.instr = fault ? '0 : word;
    r.addr  = addr;
    r.fault = fault;
    return r;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small in-order response buffer; flush and reset both empty it in one edge.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter type T     = rsp_t,
  parameter int  DEPTH = IMEM_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign head    = store[rd_ptr];

  // NOTE: storage is deliberately not reset; count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // NOTE: default first so every path assigns count_nxt and no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction-memory fetch port: synchronous-read word memory, one-cycle in-flight
// stage and a 2-entry response FIFO. Optional IMEM_FAULT_CHECK_EN flags misaligned
// or out-of-range fetches. wr_addr is a word index (aliases modulo DEPTH).
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = IMEM_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_instr,
  output logic [XLEN-1:0] rsp_addr,
  output logic            rsp_fault,
  input  logic            rsp_ready,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(IMEM_FIFO_DEPTH + 1);

  logic [XLEN-1:0]  mem [DEPTH] = '{default: '0};
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             addr_fault;
  logic             unused_bits;

  logic             live;
  logic             inflight_valid;
  rsp_t             inflight;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  rsp_t             fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] outstanding;

  rsp_t             head;
  logic             accept;
  logic             take;
  logic             take_inflight;

  assign rd_idx = req_addr[IDX_W+1:2];
  assign wr_idx = wr_addr[IDX_W-1:0];

`ifdef IMEM_FAULT_CHECK_EN
  assign addr_fault  = (req_addr[1:0] != 2'b00) || (req_addr >= XLEN'(DEPTH * 4));
  assign unused_bits = ^{wr_addr[XLEN-1:IDX_W], fifo_full};
`else
  assign addr_fault  = 1'b0;
  assign unused_bits = ^{req_addr[XLEN-1:IDX_W+2], req_addr[1:0],
                         wr_addr[XLEN-1:IDX_W], fifo_full};
`endif

  // Accept only while everything already accepted still fits in the FIFO, so
  // the decision never depends on whether the consumer pops this cycle.
  assign outstanding   = fifo_count + CNT_W'(inflight_valid);
  assign req_ready     = live && reset && !wr_en && (outstanding < CNT_W'(IMEM_FIFO_DEPTH));
  assign accept        = req_valid && req_ready;

  assign rsp_valid     = reset && (inflight_valid || !fifo_empty);
  assign head          = fifo_empty ? inflight : fifo_head;
  assign take          = rsp_valid && rsp_ready;
  assign take_inflight = take && fifo_empty;
  assign fifo_pop      = take && !fifo_empty;
  assign fifo_push     = inflight_valid && !take_inflight && !flush;

  assign rsp_instr = rsp_valid ? head.instr : '0;
  assign rsp_addr  = rsp_valid ? head.addr  : '0;
  assign rsp_fault = rsp_valid ? head.fault : 1'b0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // The in-flight slot lives exactly one cycle: it is consumed directly,
  // moved into the FIFO, or discarded by flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      live           <= 1'b0;
      inflight_valid <= 1'b0;
      inflight       <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        inflight_valid <= 1'b1;
        inflight       <= make_rsp(mem[rd_idx], req_addr, addr_fault);
      end else begin
        inflight_valid <= 1'b0;
      end
    end
  end

  imem_rsp_fifo #(
    .T     (rsp_t),
    .DEPTH (IMEM_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (inflight),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: directed scenarios then random traffic,
// checked against a queue-based model of accepted-but-not-consumed fetches.
module tb_imem_fetch_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_fault;
  logic        rsp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always #5 clk = ~clk;

  imem_fetch_port #(.DEPTH(16), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .rsp_ready (rsp_ready),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        taken_q[$];
  logic [31:0] model_mem [16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          accept_cnt = 0;
  logic [31:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] a);
    exp_t e;
    e.addr = a;
`ifdef IMEM_FAULT_CHECK_EN
    e.fault = (a % 4 != 0) || (a >= 32'd64);
`else
    e.fault = 1'b0;
`endif
    e.instr = e.fault ? 32'h0 : model_mem[int'((a >> 2) % 32'd16)];
    return e;
  endfunction

  // Monitor: inputs settle by the falling edge, so handshakes seen here are the
  // ones the next rising edge will act on.
  initial begin
    logic        live_m;
    logic        prev_stall;
    logic [31:0] prev_instr;
    logic [31:0] prev_addr;
    logic        prev_fault;
    exp_t        e;
    live_m = 1'b0;
    prev_stall = 1'b0;
    prev_instr = '0;
    prev_addr = '0;
    prev_fault = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, live_m && reset && !wr_en && (sb_q.size() < 2));
      check("rsp_valid", rsp_valid, reset && (sb_q.size() != 0));
      if (!reset) check("reset_outputs", rsp_instr | rsp_addr | {31'b0, rsp_fault}, 32'h0);
      if (prev_stall && reset) begin
        check("hold_instr", rsp_instr, prev_instr);
        check("hold_addr", rsp_addr, prev_addr);
        check("hold_fault", rsp_fault, prev_fault);
      end
      prev_stall = reset && !flush && rsp_valid && !rsp_ready;
      prev_instr = rsp_instr;
      prev_addr  = rsp_addr;
      prev_fault = rsp_fault;
      if (rsp_valid && rsp_ready && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("rsp_instr", rsp_instr, e.instr);
        check("rsp_addr", rsp_addr, e.addr);
        check("rsp_fault", rsp_fault, e.fault);
        taken_q.push_back('{rsp_instr, rsp_addr, rsp_fault});
      end
      if (!reset || flush) sb_q.delete();
      if (req_valid && req_ready) begin
        sb_q.push_back(predict(req_addr));
        accept_cnt++;
      end
      if (wr_en) model_mem[wr_addr[3:0]] = wr_data;
      live_m = reset;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = w;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a);
    logic got;
    got = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      got = req_ready;
      @(posedge clk);
      #1;
    end
    if (!got) check("send_timeout", 32'(got), 32'h1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'h0);
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    finish_run();
  end

  initial begin
    int a0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) write_word(i, prog[i]);
    write_word(8, 32'h13579BDF);

    // back-to-back stream
    taken_q.delete();
    rsp_ready = 1'b1;
    send(32'h0); send(32'h4); send(32'h8); send(32'hC);
    drain();
    check("stream_count", 32'(taken_q.size()), 32'd4);
    if (taken_q.size() == 4) begin
      check("stream_w2", taken_q[2].instr, 32'h002081B3);
      check("stream_a3", taken_q[3].addr, 32'hC);
    end

    // backpressure: exactly two accepts
    rsp_ready = 1'b0;
    a0 = accept_cnt;
    req_valid = 1'b1;
    req_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      req_addr = 32'(accept_cnt - a0) * 4;
    end
    req_valid = 1'b0;
    #1;
    check("stall_accepts", 32'(accept_cnt - a0), 32'd2);
    check("stall_ready", 32'(req_ready), 32'h0);
    taken_q.delete();
    drain();
    check("stall_drain", 32'(taken_q.size()), 32'd2);
    if (taken_q.size() == 2) check("stall_order", taken_q[1].addr, 32'h4);

    // flush with two buffered entries
    rsp_ready = 1'b0;
    send(32'h0); send(32'h4);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h20;
    tick();
    flush = 1'b0;
    send(32'h20);
    taken_q.delete();
    drain();
    check("flush_count", 32'(taken_q.size()), 32'd1);
    if (taken_q.size() == 1) begin
      check("flush_addr", taken_q[0].addr, 32'h20);
      check("flush_word8", taken_q[0].instr, 32'h13579BDF);
    end

    // misaligned and out-of-range fetches
    taken_q.delete();
    rsp_ready = 1'b1;
    send(32'h6); send(32'h40);
    drain();
    check("fault_count", 32'(taken_q.size()), 32'd2);
    if (taken_q.size() == 2) begin
`ifdef IMEM_FAULT_CHECK_EN
      check("fault_mis", 32'(taken_q[0].fault), 32'h1);
      check("fault_oor", 32'(taken_q[1].fault), 32'h1);
      check("fault_zero", taken_q[1].instr, 32'h0);
`else
      check("alias_fault", 32'(taken_q[1].fault), 32'h0);
      check("alias_word0", taken_q[1].instr, 32'h00500093);
      check("ignore_low", taken_q[0].instr, 32'h00A00113);
`endif
    end

    // reset with two pending
    rsp_ready = 1'b0;
    send(32'h0); send(32'h4);
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    tick();
    reset = 1'b1;
    taken_q.delete();
    send(32'h4);
    drain();
    check("rst_refetch_cnt", 32'(taken_q.size()), 32'd1);
    if (taken_q.size() == 1) check("rst_refetch", taken_q[0].instr, 32'h00A00113);

    // write then read next cycle
    req_valid = 1'b1;
    req_addr = 32'h14;
    wr_en = 1'b1;
    wr_addr = 32'd5;
    wr_data = 32'hDEADBEEF;
    #1;
    check("wr_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    a0 = accept_cnt;
    taken_q.delete();
    send(32'h14);
    check("wr_next_accept", 32'(accept_cnt - a0), 32'd1);
    drain();
    if (taken_q.size() == 1) check("wr_readback", taken_q[0].instr, 32'hDEADBEEF);
    else check("wr_read_cnt", 32'(taken_q.size()), 32'd1);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(3) != 0);
      case ($urandom_range(7))
        0:       req_addr = 32'($urandom_range(127));
        1:       req_addr = 32'($urandom_range(63, 16)) * 4;
        default: req_addr = 32'($urandom_range(15)) * 4;
      endcase
      rsp_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      wr_en     = ($urandom_range(15) == 0);
      wr_addr   = 32'($urandom_range(15));
      wr_data   = $urandom;
      reset     = ($urandom_range(63) != 0);
      tick();
    end
    req_valid = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    reset = 1'b1;
    drain();
    repeat (3) tick();
    finish_run();
  end

endmodule
